// File: rtl/mc_cu_if.sv
// rtl/mc_cu_if.sv - control-unit to datapath signal bundle for the multi-cycle MIPS subset
interface mc_cu_if;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic [2:0] state;
    logic       wpc;
    logic       wir;
    logic       wmem;
    logic       wreg;
    logic       iord;
    logic       regrt;
    logic       m2reg;
    logic       jal;
    logic       sext;
    logic       shift;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluc;
    logic [1:0] pcsource;
    logic       ill;

    modport master (
        input  op, func, z,
        output state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
               alusrca, alusrcb, aluc, pcsource, ill
    );

    modport slave (
        output op, func, z,
        input  state, wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
               alusrca, alusrcb, aluc, pcsource, ill
    );
endinterface

// File: rtl/mc_cu.sv
// rtl/mc_cu.sv - multi-cycle IF/ID/EXE/MEM/WB control unit with memory wait states
module mc_cu #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic     clock,
    input  logic     resetn,
    mc_cu_if.master  cu
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        K_ILL, K_R, K_SH, K_JR, K_ADDI, K_IALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL
    } kind_t;

    localparam logic [3:0] WAIT     = 4'(MEM_WAIT);
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    state_t     state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    kind_t      kind;
    logic [3:0] alu_fn;
    logic       done;

    logic       wpc_c, wir_c, wmem_c, wreg_c, iord_c, regrt_c, m2reg_c, jal_c;
    logic       sext_c, shift_c, alusrca_c, ill_c;
    logic [1:0] alusrcb_c, pcsource_c;
    logic [3:0] aluc_c;

    assign done = (wcnt_q == WAIT);

    always_comb begin
        kind   = K_ILL;
        alu_fn = ALU_ADD;
        case (cu.op)
            6'b000000: begin
                case (cu.func)
                    6'b100000: begin kind = K_R;  alu_fn = ALU_ADD; end
                    6'b100010: begin kind = K_R;  alu_fn = ALU_SUB; end
                    6'b100100: begin kind = K_R;  alu_fn = ALU_AND; end
                    6'b100101: begin kind = K_R;  alu_fn = ALU_OR;  end
                    6'b100110: begin kind = K_R;  alu_fn = ALU_XOR; end
                    6'b000000: begin kind = K_SH; alu_fn = ALU_SLL; end
                    6'b000010: begin kind = K_SH; alu_fn = ALU_SRL; end
                    6'b000011: begin kind = K_SH; alu_fn = ALU_SRA; end
                    6'b001000: kind = K_JR;
                    default:   kind = K_ILL;
                endcase
            end
            6'b001000: begin kind = K_ADDI; alu_fn = ALU_ADD; end
            6'b001100: begin kind = K_IALU; alu_fn = ALU_AND; end
            6'b001101: begin kind = K_IALU; alu_fn = ALU_OR;  end
            6'b001110: begin kind = K_IALU; alu_fn = ALU_XOR; end
            6'b001111: begin kind = K_IALU; alu_fn = ALU_LUI; end
            6'b100011: kind = K_LW;
            6'b101011: kind = K_SW;
            6'b000100: kind = K_BEQ;
            6'b000101: kind = K_BNE;
            6'b000010: kind = K_J;
            6'b000011: kind = K_JAL;
            default:   kind = K_ILL;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IF;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = 4'd0;
        case (state_q)
            S_IF:  if (done) state_d = S_ID;
            S_ID: begin
                case (kind)
                    K_J, K_JAL, K_JR, K_ILL: state_d = S_IF;
                    default:                 state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                case (kind)
                    K_LW, K_SW:                     state_d = S_MEM;
                    K_R, K_SH, K_ADDI, K_IALU:      state_d = S_WB;
                    default:                        state_d = S_IF;
                endcase
            end
            S_MEM: if (done) state_d = (kind == K_LW) ? S_WB : S_IF;
            S_WB:  state_d = S_IF;
            default: state_d = S_IF;
        endcase
        // Memory states stall in place until the wait counter reaches MEM_WAIT.
        if ((state_q == S_IF || state_q == S_MEM) && !done) begin
            wcnt_d = wcnt_q + 4'd1;
        end
    end

    always_comb begin
        wpc_c      = 1'b0;
        wir_c      = 1'b0;
        wmem_c     = 1'b0;
        wreg_c     = 1'b0;
        iord_c     = 1'b0;
        regrt_c    = 1'b0;
        m2reg_c    = 1'b0;
        jal_c      = 1'b0;
        sext_c     = 1'b0;
        shift_c    = 1'b0;
        alusrca_c  = 1'b0;
        alusrcb_c  = 2'b00;
        aluc_c     = ALU_ADD;
        pcsource_c = 2'b00;
        ill_c      = 1'b0;
        case (state_q)
            S_IF: begin
                if (done) begin
                    wir_c     = 1'b1;
                    wpc_c     = 1'b1;
                    alusrcb_c = 2'b01;
                end
            end
            S_ID: begin
                // Branch target is computed here so EXE can reuse the single ALU for the compare.
                alusrcb_c = 2'b11;
                sext_c    = 1'b1;
                case (kind)
                    K_J:   begin wpc_c = 1'b1; pcsource_c = 2'b11; end
                    K_JAL: begin wpc_c = 1'b1; pcsource_c = 2'b11; wreg_c = 1'b1; jal_c = 1'b1; end
                    K_JR:  begin wpc_c = 1'b1; pcsource_c = 2'b10; end
                    K_ILL: ill_c = 1'b1;
                    default: ;
                endcase
            end
            S_EXE: begin
                alusrca_c = 1'b1;
                case (kind)
                    K_R:  aluc_c = alu_fn;
                    K_SH: begin aluc_c = alu_fn; shift_c = 1'b1; end
                    K_ADDI, K_IALU: begin
                        alusrcb_c = 2'b10;
                        aluc_c    = alu_fn;
                        sext_c    = (kind == K_ADDI);
                    end
                    K_LW, K_SW: begin
                        alusrcb_c = 2'b10;
                        sext_c    = 1'b1;
                    end
                    K_BEQ, K_BNE: begin
                        aluc_c     = ALU_SUB;
                        pcsource_c = 2'b01;
                        wpc_c      = (kind == K_BEQ) ? cu.z : ~cu.z;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                iord_c = 1'b1;
                if (done && kind == K_SW) wmem_c = 1'b1;
            end
            S_WB: begin
                wreg_c  = 1'b1;
                regrt_c = (kind == K_ADDI || kind == K_IALU || kind == K_LW);
                m2reg_c = (kind == K_LW);
            end
            default: ;
        endcase
    end

    // Write enables are gated by reset so an aborted store cannot complete.
    assign cu.state    = state_q;
    assign cu.wpc      = wpc_c  & resetn;
    assign cu.wir      = wir_c  & resetn;
    assign cu.wmem     = wmem_c & resetn;
    assign cu.wreg     = wreg_c & resetn;
    assign cu.ill      = ill_c  & resetn;
    assign cu.iord     = iord_c;
    assign cu.regrt    = regrt_c;
    assign cu.m2reg    = m2reg_c;
    assign cu.jal      = jal_c;
    assign cu.sext     = sext_c;
    assign cu.shift    = shift_c;
    assign cu.alusrca  = alusrca_c;
    assign cu.alusrcb  = alusrcb_c;
    assign cu.aluc     = aluc_c;
    assign cu.pcsource = pcsource_c;

endmodule

// File: tb/tb_mc_cu.sv
// tb/tb_mc_cu.sv - randomized model-based bench for mc_cu at MEM_WAIT 0, 2 and 3
module tb_mc_cu;

    localparam int KR = 0, KSH = 1, KJR = 2, KADDI = 3, KIALU = 4, KLW = 5, KSW = 6;
    localparam int KBEQ = 7, KBNE = 8, KJ = 9, KJAL = 10, KILL = 11;

    logic        clock = 1'b0;
    logic        resetn;
    logic [5:0]  op, func;
    logic        z;
    int          sel;
    int          wt [3] = '{0, 2, 3};
    int          checks = 0;
    int          failures = 0;
    logic        exp_on;
    logic [22:0] exp_vec;
    logic [22:0] obs0, obs1, obs2, obs_sel;

    logic [5:0]  t_op   [20];
    logic [5:0]  t_func [20];
    int          t_kind [20];
    logic [3:0]  t_aluc [20];

    always #5 clock = ~clock;

    mc_cu_if if0 ();
    mc_cu_if if1 ();
    mc_cu_if if2 ();

    assign if0.op = op;  assign if0.func = func;  assign if0.z = z;
    assign if1.op = op;  assign if1.func = func;  assign if1.z = z;
    assign if2.op = op;  assign if2.func = func;  assign if2.z = z;

    mc_cu #(.MEM_WAIT(0)) u_dut0 (.clock(clock), .resetn(resetn), .cu(if0.master));
    mc_cu #(.MEM_WAIT(2)) u_dut1 (.clock(clock), .resetn(resetn), .cu(if1.master));
    mc_cu #(.MEM_WAIT(3)) u_dut2 (.clock(clock), .resetn(resetn), .cu(if2.master));

    assign obs0 = {if0.state, if0.wpc, if0.wir, if0.wmem, if0.wreg, if0.iord, if0.regrt, if0.m2reg,
                   if0.jal, if0.sext, if0.shift, if0.alusrca, if0.alusrcb, if0.aluc, if0.pcsource, if0.ill};
    assign obs1 = {if1.state, if1.wpc, if1.wir, if1.wmem, if1.wreg, if1.iord, if1.regrt, if1.m2reg,
                   if1.jal, if1.sext, if1.shift, if1.alusrca, if1.alusrcb, if1.aluc, if1.pcsource, if1.ill};
    assign obs2 = {if2.state, if2.wpc, if2.wir, if2.wmem, if2.wreg, if2.iord, if2.regrt, if2.m2reg,
                   if2.jal, if2.sext, if2.shift, if2.alusrca, if2.alusrcb, if2.aluc, if2.pcsource, if2.ill};

    always_comb begin
        case (sel)
            1:       obs_sel = obs1;
            2:       obs_sel = obs2;
            default: obs_sel = obs0;
        endcase
    end

    // Expected outputs for one cycle of an instruction, straight from the per-phase control table.
    function automatic logic [22:0] model(int k, logic [3:0] ac, int ph, bit done, logic zz);
        logic wpc_ = 0, wir_ = 0, wmem_ = 0, wreg_ = 0, iord_ = 0, regrt_ = 0, m2reg_ = 0;
        logic jal_ = 0, sext_ = 0, shift_ = 0, asa = 0, ill_ = 0;
        logic [1:0] asb = 0, pcs = 0;
        logic [3:0] alu = 0;
        case (ph)
            0: if (done) begin wir_ = 1; wpc_ = 1; asb = 2'b01; end
            1: begin
                asb = 2'b11; sext_ = 1;
                if (k == KJ)   begin wpc_ = 1; pcs = 2'b11; end
                if (k == KJAL) begin wpc_ = 1; pcs = 2'b11; wreg_ = 1; jal_ = 1; end
                if (k == KJR)  begin wpc_ = 1; pcs = 2'b10; end
                if (k == KILL) ill_ = 1;
            end
            2: begin
                asa = 1;
                if (k == KR || k == KSH) begin alu = ac; shift_ = (k == KSH); end
                if (k == KADDI || k == KIALU) begin asb = 2'b10; alu = ac; sext_ = (k == KADDI); end
                if (k == KLW || k == KSW) begin asb = 2'b10; sext_ = 1; end
                if (k == KBEQ || k == KBNE) begin
                    alu = 4'b0100; pcs = 2'b01;
                    wpc_ = (k == KBEQ) ? zz : !zz;
                end
            end
            3: begin iord_ = 1; wmem_ = (k == KSW) && done; end
            4: begin
                wreg_ = 1;
                regrt_ = (k == KADDI || k == KIALU || k == KLW);
                m2reg_ = (k == KLW);
            end
            default: ;
        endcase
        return {3'(ph), wpc_, wir_, wmem_, wreg_, iord_, regrt_, m2reg_, jal_, sext_, shift_, asa,
                asb, alu, pcs, ill_};
    endfunction

    always @(negedge clock) begin
        if (exp_on) begin
            checks++;
            if (obs_sel !== exp_vec) begin
                failures++;
                $display("FAIL cycle_compare dut=%0d t=%0t got=%h expected=%h", sel, $time, obs_sel, exp_vec);
            end
        end
    end

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic do_reset();
        exp_on = 1'b0;
        resetn = 1'b0;
        #1;
        check("reset_gated", 23'({obs_sel[22:16], obs_sel[0]}), 23'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
    endtask

    task automatic classify(input logic [5:0] o, input logic [5:0] f, output int k, output logic [3:0] ac);
        k = KILL;
        ac = 4'd0;
        for (int i = 0; i < 20; i++) begin
            if (t_op[i] == o && (o != 6'd0 || t_func[i] == f)) begin
                k = t_kind[i];
                ac = t_aluc[i];
            end
        end
    endtask

    // Called one step after a rising edge; leaves the bench at the same point in the next instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                             input int stop_at, output int ncyc);
        int k;
        logic [3:0] ac;
        int phs[$];
        classify(o, f, k, ac);
        phs.push_back(0);
        phs.push_back(1);
        if (!(k == KJ || k == KJAL || k == KJR || k == KILL)) phs.push_back(2);
        if (k == KLW || k == KSW) phs.push_back(3);
        if (k == KLW || k == KR || k == KSH || k == KADDI || k == KIALU) phs.push_back(4);
        ncyc = 0;
        op = o;
        func = f;
        foreach (phs[p]) begin
            int len;
            len = (phs[p] == 0 || phs[p] == 3) ? wt[sel] + 1 : 1;
            for (int c = 0; c < len; c++) begin
                z = (zmode < 0) ? 1'($urandom) : 1'(zmode);
                exp_vec = model(k, ac, phs[p], c == len - 1, z);
                exp_on = 1'b1;
                ncyc++;
                if (ncyc == stop_at) return;
                @(posedge clock); #1;
            end
        end
    endtask

    initial begin
        int n;
        logic [5:0] ro, rf;
        t_op   = '{6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'b001000,
                   6'b001100, 6'b001101, 6'b001110, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                   6'b001111, 6'b000010, 6'b000011};
        t_func = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b000000, 6'b000010,
                   6'b000011, 6'b001000, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        t_kind = '{KR, KR, KR, KR, KR, KSH, KSH, KSH, KJR, KADDI, KIALU, KIALU, KIALU, KLW, KSW,
                   KBEQ, KBNE, KIALU, KJ, KJAL};
        t_aluc = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010, 4'b0011, 4'b0111, 4'b1111, 4'b0000,
                   4'b0000, 4'b0001, 4'b0101, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110,
                   4'b0000, 4'b0000};
        resetn = 1'b0;
        op = 6'd0;
        func = 6'd0;
        z = 1'b0;
        exp_on = 1'b0;
        exp_vec = '0;
        sel = 0;

        #2;
        check("reset_dut0", 23'({obs0[22:16], obs0[0]}), 23'd0);
        check("reset_dut1", 23'({obs1[22:16], obs1[0]}), 23'd0);
        check("reset_dut2", 23'({obs2[22:16], obs2[0]}), 23'd0);

        check("model_add_exe", model(KR, 4'b0000, 2, 1'b1, 1'b0),
              {3'd2, 11'b00000000001, 2'b00, 4'b0000, 2'b00, 1'b0});
        check("model_lw_wb", model(KLW, 4'b0000, 4, 1'b1, 1'b0),
              {3'd4, 11'b00010110000, 2'b00, 4'b0000, 2'b00, 1'b0});
        check("model_beq_exe_z1", model(KBEQ, 4'b0000, 2, 1'b1, 1'b1),
              {3'd2, 11'b10000000001, 2'b00, 4'b0100, 2'b01, 1'b0});
        check("model_jal_id", model(KJAL, 4'b0000, 1, 1'b1, 1'b0),
              {3'd1, 11'b10010001100, 2'b11, 4'b0000, 2'b11, 1'b0});

        @(posedge clock); #1;
        resetn = 1'b1;

        sel = 0;
        run_instr(6'b000000, 6'b100000, -1, 0, n);
        check("add_w0_cycles", 23'(n), 23'd4);
        run_instr(6'b000100, 6'd0, 1, 0, n);
        check("beq_z1_cycles", 23'(n), 23'd3);
        run_instr(6'b000100, 6'd0, 0, 0, n);
        check("beq_z0_cycles", 23'(n), 23'd3);
        run_instr(6'b000011, 6'd0, -1, 0, n);
        check("jal_cycles", 23'(n), 23'd2);
        run_instr(6'b111111, 6'd0, -1, 0, n);
        check("illegal_cycles", 23'(n), 23'd2);

        sel = 1;
        do_reset();
        run_instr(6'b100011, 6'd0, -1, 0, n);
        check("lw_w2_cycles", 23'(n), 23'd9);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            do_reset();
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    ro = 6'($urandom);
                    rf = 6'($urandom);
                end else begin
                    int j;
                    j = $urandom_range(0, 19);
                    ro = t_op[j];
                    rf = t_func[j];
                end
                run_instr(ro, rf, -1, 0, n);
            end
        end

        sel = 2;
        do_reset();
        run_instr(6'b101011, 6'd0, -1, 10, n);
        @(negedge clock); #1;
        check("sw_wmem_done", 23'(obs2[17]), 23'd1);
        exp_on = 1'b0;
        resetn = 1'b0;
        #1;
        check("sw_abort_wmem", 23'(obs2[17]), 23'd0);
        check("sw_abort_state", 23'(obs2[22:20]), 23'd0);
        @(posedge clock); #1;
        check("reset_hold_state", 23'(obs2[22:20]), 23'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        run_instr(6'b000000, 6'b100000, -1, 0, n);
        check("add_after_abort_cycles", 23'(n), 23'd7);
        exp_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_cu.md
# mc_cu

Multi-cycle control unit for the MIPS-subset CPU. It replaces the single-cycle decoder with a registered IF/ID/EXE/MEM/WB state machine driving a shared-memory, single-ALU datapath. It supports a parametrised number of memory wait states and flags illegal instructions. It decodes the same 20-instruction subset: add sub and or xor sll srl sra jr addi andi ori xori lw sw beq bne lui j jal.

## Interface
- MEM_WAIT, 0: extra cycles per memory access (instruction fetch and lw/sw data access); legal range 0..15.
- clock  in  1  rising-edge system clock
- resetn  in  1  asynchronous, active-low reset
- op  in  6  IR[31:26]; valid from ID onward
- func  in  6  IR[5:0]; valid from ID onward
- z  in  1  ALU zero flag, combinational from the current ALU result
- state  out  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4
- wpc  out  1  PC write enable
- wir  out  1  IR write enable
- wmem  out  1  data memory write enable
- wreg  out  1  register file write enable
- iord  out  1  memory address select: 0=PC, 1=ALU register
- regrt  out  1  destination register: 1=rt, 0=rd
- m2reg  out  1  write-back data select: 1=memory data register, 0=ALU register
- jal  out  1  write-back target is r31, data is PC
- sext  out  1  sign-extend imm16 (else zero-extend)
- shift  out  1  ALU A operand is sa
- alusrca  out  1  ALU A operand: 0=PC, 1=register A
- alusrcb  out  2  ALU B operand: 00=register B, 01=4, 10=ext imm, 11=ext imm<<2
- aluc  out  4  ALU op: add x000, sub x100, and x001, or x101, xor x010, lui x110, sll 0011, srl 0111, sra 1111
- pcsource  out  2  next PC: 00=ALU, 01=ALU register (branch target), 10=rs (jr), 11=jump address
- ill  out  1  illegal-instruction pulse

## Operation
- Internal registers: a 3-bit state register and a 4-bit wait counter wcnt. All outputs are combinational from state, wcnt, op, func and z.
- Default value of every output: 0.
- A memory state is "done" when wcnt==MEM_WAIT. When a memory state is not done, wcnt increments and the state holds. wcnt clears on every state change.
- IF:
  - Drives iord=0.
  - On the done cycle only: wir=1, wpc=1, alusrca=0, alusrcb=01, aluc=add, pcsource=00.
  - Moves to ID when done.
- ID:
  - Drives alusrca=0, alusrcb=11, sext=1, aluc=add. This latches the branch target into the ALU register.
  - j: wpc=1, pcsource=11, next state IF.
  - jal: wpc=1, pcsource=11, wreg=1, jal=1, next state IF.
  - jr: wpc=1, pcsource=10, next state IF.
  - Undecoded op/func: ill=1, all write enables 0, next state IF.
  - All other instructions: next state EXE.
- EXE:
  - R-type: alusrca=1, shift=1 for sll/srl/sra, alusrcb=00, aluc per func. Next state WB.
  - addi/andi/ori/xori/lui: alusrca=1, alusrcb=10, aluc per op, sext=1 only for addi. Next state WB.
  - lw/sw: alusrca=1, alusrcb=10, sext=1, aluc=add. Next state MEM.
  - beq: alusrca=1, alusrcb=00, aluc=sub (0100), pcsource=01, wpc=z. Next state IF.
  - bne: same controls as beq but wpc=~z. Next state IF.
- MEM:
  - Drives iord=1.
  - sw: wmem=1 on the done cycle only, then IF.
  - lw: on done, next state WB.
- WB:
  - Drives wreg=1.
  - regrt=1 for I-type ALU ops and lw.
  - m2reg=1 for lw.
  - Next state IF.

## Timing
- Reset: resetn=0 forces state=IF and wcnt=0 immediately. While resetn=0, wpc, wir, wmem, wreg and ill are gated to 0. The first IF cycle starts at the first rising edge after release.
- Cycles per instruction, with W=MEM_WAIT:
  - j/jal/jr/illegal: 2+W
  - beq/bne: 3+W
  - R-type and I-type ALU ops: 4+W
  - sw: 4+2W
  - lw: 5+2W
- Write enables are single-cycle pulses. No write enable is ever asserted on a non-done memory cycle.
- Reset asserted mid-instruction aborts it, including a pending sw: wmem drops asynchronously.
- z is sampled only in EXE of beq/bne.

## Test plan
- MEM_WAIT=0, add (op=0, func=100000):
  - states 0,1,2,4 over 4 cycles
  - EXE: aluc=0000, alusrca=1, alusrcb=00
  - WB: wreg=1, regrt=0
  - then IF.
- MEM_WAIT=2, lw (op=100011):
  - IF lasts 3 cycles; wir/wpc are asserted only in the third
  - EXE: alusrcb=10, sext=1
  - MEM lasts 3 cycles with iord=1
  - WB: wreg=1, m2reg=1, regrt=1
  - 9 cycles total.
- beq with z=1, then z=0:
  - EXE: pcsource=01, aluc=0100
  - wpc=1 in the first case, 0 in the second
  - each takes 3 cycles.
- jal (op=000011):
  - ID: wpc=1, wreg=1, jal=1, pcsource=11
  - next state IF; 2 cycles total.
- Illegal op=111111:
  - ID: ill=1 for exactly one cycle, no write enable asserted
  - returns to IF.
- MEM_WAIT=3, sw with resetn pulled low in the MEM done cycle:
  - wmem falls to 0 immediately
  - state=0 while reset is held
  - after release, IF restarts with wcnt=0.
